// File: rtl/cache_defs_pkg.sv
// Shared cache address/word geometry used by the line store and its LRU.
package cache_defs_pkg;

    localparam int unsigned ADDR_BITS        = 32;
    localparam int unsigned WORD_BYTES       = 4;
    localparam int unsigned WORD_BITS        = 32;
    localparam int unsigned WORD_BYTES_WIDTH = 2;

    // Command decoded from the strobes after priority resolution.
    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_LOOKUP  = 3'd1,
        CMD_EDIT    = 3'd2,
        CMD_STORE   = 3'd3,
        CMD_INVALID = 3'd4
    } cmd_e;

    function automatic int unsigned index_width(input int unsigned tag_bits,
                                                input int unsigned line_words_width);
        return ADDR_BITS - tag_bits - line_words_width - WORD_BYTES_WIDTH;
    endfunction

    function automatic int unsigned index_lsb(input int unsigned line_words_width);
        return WORD_BYTES_WIDTH + line_words_width;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU ages: touch makes a way youngest, victim is the oldest way.
module cache_lru #(
    parameter int unsigned SET_W = 6,
    parameter int unsigned WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_en,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] oldest_way
);

    localparam int unsigned SETS = 1 << SET_W;
    localparam int unsigned WAYS = 1 << WAY_W;

    logic [WAY_W-1:0] age_q [SETS][WAYS];

    // Ages stay a permutation of 0..WAYS-1; reset orders them by way index.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_q[touch_set][w] <= '0;
                end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_q[touch_set][w] <= age_q[touch_set][w] + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        oldest_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (age_q[query_set][w] == WAY_W'(WAYS - 1)) begin
                oldest_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative line store: tags, valid/dirty, word data and LRU victim
// selection, all updated and reported on the falling clock edge.
module cache_assoc
    import cache_defs_pkg::*;
#(
    parameter  int unsigned TAG_BITS         = 22,
    parameter  int unsigned LINE_WORDS_WIDTH = 2,
    parameter  int unsigned WAYS_WIDTH       = 1,
    localparam int unsigned WAY_W            = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 lookup,
    input  logic                 store,
    input  logic                 edit,
    input  logic                 invalid,
    input  logic [WORD_BITS-1:0] din,
    output logic                 hit,
    output logic [WAY_W-1:0]     hit_way,
    output logic [WORD_BITS-1:0] dout,
    output logic [WAY_W-1:0]     victim_way,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag
);

    localparam int unsigned INDEX_WIDTH = index_width(TAG_BITS, LINE_WORDS_WIDTH);
    localparam int unsigned INDEX_LSB   = index_lsb(LINE_WORDS_WIDTH);
    localparam int unsigned SETS        = 1 << INDEX_WIDTH;
    localparam int unsigned WAYS        = 1 << WAYS_WIDTH;
    localparam int unsigned LINE_WORDS  = 1 << LINE_WORDS_WIDTH;

    logic [TAG_BITS-1:0]         a_tag;
    logic [INDEX_WIDTH-1:0]      a_set;
    logic [LINE_WORDS_WIDTH-1:0] a_word;
    logic                        unused_byte_bits;

    assign a_tag            = addr[ADDR_BITS-1 -: TAG_BITS];
    assign a_set            = addr[INDEX_LSB +: INDEX_WIDTH];
    assign a_word           = addr[WORD_BYTES_WIDTH +: LINE_WORDS_WIDTH];
    assign unused_byte_bits = ^addr[WORD_BYTES_WIDTH-1:0];

    logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
    logic [WORD_BITS-1:0] data_mem [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]      valid_q  [SETS];
    logic [WAYS-1:0]      dirty_q  [SETS];

    logic [WAYS-1:0]  match;
    logic             match_any;
    logic [WAY_W-1:0] match_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] target;
    cmd_e             cmd;

    // Match and invalid-way search; descending loops leave the lowest index.
    always_comb begin
        match     = '0;
        match_way = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            match[w] = valid_q[a_set][w] && (tag_mem[a_set][w] == a_tag);
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (match[w]) begin
                match_way = WAY_W'(w);
            end
            if (!valid_q[a_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign match_any = |match;
    assign victim    = inv_found ? inv_way : lru_way;
    assign target    = match_any ? match_way : victim;

    // Strobe priority: invalid > store > edit > lookup.
    always_comb begin
        cmd = CMD_NONE;
        if (invalid) begin
            cmd = CMD_INVALID;
        end else if (store) begin
            cmd = CMD_STORE;
        end else if (edit) begin
            cmd = CMD_EDIT;
        end else if (lookup) begin
            cmd = CMD_LOOKUP;
        end
    end

    generate
        if (WAYS_WIDTH > 0) begin : g_lru
            logic touch_en;
            assign touch_en = (cmd == CMD_STORE) ||
                              (match_any && (cmd == CMD_EDIT || cmd == CMD_LOOKUP));
            cache_lru #(
                .SET_W (INDEX_WIDTH),
                .WAY_W (WAY_W)
            ) u_lru (
                .clk        (clk),
                .rst        (rst),
                .touch_en   (touch_en),
                .touch_set  (a_set),
                .touch_way  (target),
                .query_set  (a_set),
                .oldest_way (lru_way)
            );
        end else begin : g_direct
            assign lru_way = '0;
        end
    endgenerate

    // Tags and data carry no reset; valid bits gate their use.
    always_ff @(negedge clk) begin
        if (cmd == CMD_STORE) begin
            tag_mem[a_set][target]          <= a_tag;
            data_mem[a_set][target][a_word] <= din;
        end else if (cmd == CMD_EDIT && match_any) begin
            data_mem[a_set][match_way][a_word] <= din;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (cmd)
                CMD_INVALID: begin
                    if (match_any) begin
                        valid_q[a_set][match_way] <= 1'b0;
                        dirty_q[a_set][match_way] <= 1'b0;
                    end
                end
                CMD_STORE: begin
                    valid_q[a_set][target] <= 1'b1;
                    dirty_q[a_set][target] <= 1'b0;
                end
                CMD_EDIT: begin
                    if (match_any) begin
                        dirty_q[a_set][match_way] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs capture the state as it was before this edge's write.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            hit        <= 1'b0;
            hit_way    <= '0;
            dout       <= '0;
            victim_way <= '0;
            valid      <= 1'b0;
            dirty      <= 1'b0;
            tag        <= '0;
        end else begin
            hit        <= match_any;
            hit_way    <= match_any ? match_way : '0;
            dout       <= match_any ? data_mem[a_set][match_way][a_word] : '0;
            victim_way <= victim;
            valid      <= valid_q[a_set][victim];
            dirty      <= dirty_q[a_set][victim];
            tag        <= tag_mem[a_set][victim];
        end
    end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: expected outputs queued per step, checked after the edge.
module tb_cache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        lookup = 1'b0, store = 1'b0, edit = 1'b0, invalid = 1'b0;
    logic [31:0] din = '0;
    logic        hit;
    logic [0:0]  hit_way;
    logic [31:0] dout;
    logic [0:0]  victim_way;
    logic        valid, dirty;
    logic [21:0] tag;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] C_HIT = 7'd1,  C_WAY = 7'd2,  C_DOUT = 7'd4, C_VIC = 7'd8,
                           C_VAL = 7'd16, C_DRT = 7'd32, C_TAG = 7'd64;

    typedef struct {
        logic [6:0]  chk;
        logic        hit;
        logic        hw;
        logic [31:0] dout;
        logic        vw;
        logic        valid;
        logic        dirty;
        logic [21:0] tag;
    } exp_t;

    exp_t sb[$];

    cache_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .lookup     (lookup),
        .store      (store),
        .edit       (edit),
        .invalid    (invalid),
        .din        (din),
        .hit        (hit),
        .hit_way    (hit_way),
        .dout       (dout),
        .victim_way (victim_way),
        .valid      (valid),
        .dirty      (dirty),
        .tag        (tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [6:0] chk, input logic h, input logic hw,
                                input logic [31:0] d, input logic vw, input logic v,
                                input logic dr, input logic [21:0] t);
        exp_t e;
        e.chk = chk; e.hit = h; e.hw = hw; e.dout = d;
        e.vw = vw; e.valid = v; e.dirty = dr; e.tag = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, expv);
        end
    endtask

    // Called just after a posedge: drive, let the falling edge act, compare at next posedge.
    task automatic step(input string name, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] d, input exp_t e);
        exp_t got;
        {invalid, store, edit, lookup} = cmd;
        addr = a;
        din  = d;
        sb.push_back(e);
        @(posedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            if (got.chk[0]) check({name, ".hit"},   32'(hit),        32'(got.hit));
            if (got.chk[1]) check({name, ".way"},   32'(hit_way),    32'(got.hw));
            if (got.chk[2]) check({name, ".dout"},  dout,            got.dout);
            if (got.chk[3]) check({name, ".vic"},   32'(victim_way), 32'(got.vw));
            if (got.chk[4]) check({name, ".valid"}, 32'(valid),      32'(got.valid));
            if (got.chk[5]) check({name, ".dirty"}, 32'(dirty),      32'(got.dirty));
            if (got.chk[6]) check({name, ".tag"},   32'(tag),        32'(got.tag));
        end
        {invalid, store, edit, lookup} = 4'b0000;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".hit"},   32'(hit),        32'd0);
        check({name, ".way"},   32'(hit_way),    32'd0);
        check({name, ".dout"},  dout,            32'd0);
        check({name, ".vic"},   32'(victim_way), 32'd0);
        check({name, ".valid"}, 32'(valid),      32'd0);
        check({name, ".dirty"}, 32'(dirty),      32'd0);
        check({name, ".tag"},   32'(tag),        32'd0);
    endtask

    localparam logic [3:0] LK = 4'b0001, ED = 4'b0010, ST = 4'b0100, IV = 4'b1000;
    localparam logic [6:0] MISS  = C_HIT | C_WAY | C_DOUT | C_VIC;
    localparam logic [6:0] HITW  = C_HIT | C_WAY;
    localparam logic [6:0] HITD  = C_HIT | C_WAY | C_DOUT;
    localparam logic [6:0] ALL   = 7'h7F;

    initial begin
        repeat (3) @(posedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;

        // 1: empty cache
        step("t1_lk40", LK, 32'h0000_0040, 0, ex(MISS | C_VAL | C_DRT, 0, 0, 0, 0, 0, 0, 0));

        // 2: refill way 0
        step("t2_st0", ST, 32'h0000_1040, 32'hA0, ex(MISS | C_VAL, 0, 0, 0, 0, 0, 0, 0));
        step("t2_st1", ST, 32'h0000_1044, 32'hA1, ex(HITW, 1, 0, 0, 0, 0, 0, 0));
        step("t2_st2", ST, 32'h0000_1048, 32'hA2, ex(HITW, 1, 0, 0, 0, 0, 0, 0));
        step("t2_st3", ST, 32'h0000_104C, 32'hA3, ex(HITW, 1, 0, 0, 0, 0, 0, 0));
        step("t2_lk48", LK, 32'h0000_1048, 0, ex(HITD | C_VIC | C_VAL, 1, 0, 32'hA2, 1, 0, 0, 0));

        // 3: second line goes to the free way, then LRU picks the older line
        step("t3_st0", ST, 32'h0000_2040, 32'hB0, ex(MISS | C_VAL, 0, 0, 0, 1, 0, 0, 0));
        step("t3_st1", ST, 32'h0000_2044, 32'hB1, ex(HITW, 1, 1, 0, 0, 0, 0, 0));
        step("t3_st2", ST, 32'h0000_2048, 32'hB2, ex(HITW, 1, 1, 0, 0, 0, 0, 0));
        step("t3_st3", ST, 32'h0000_204C, 32'hB3, ex(HITW, 1, 1, 0, 0, 0, 0, 0));
        step("t3_lk10", LK, 32'h0000_1040, 0, ex(HITD, 1, 0, 32'hA0, 0, 0, 0, 0));
        step("t3_lk30", LK, 32'h0000_3040, 0, ex(ALL, 0, 0, 0, 1, 1, 0, 22'h8));
        step("t3_lk2C", LK, 32'h0000_204C, 0, ex(HITD, 1, 1, 32'hB3, 0, 0, 0, 0));

        // 4: write hit sets dirty; edit miss changes nothing
        step("t4_ed", ED, 32'h0000_1044, 32'hDEADBEEF, ex(HITD, 1, 0, 32'hA1, 0, 0, 0, 0));
        step("t4_lk44", LK, 32'h0000_1044, 0, ex(HITD, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        step("t4_lk20", LK, 32'h0000_2040, 0, ex(HITD, 1, 1, 32'hB0, 0, 0, 0, 0));
        step("t4_lk30", LK, 32'h0000_3040, 0, ex(ALL, 0, 0, 0, 0, 1, 1, 22'h4));
        step("t4_ed30", ED, 32'h0000_3044, 32'h12345678, ex(MISS, 0, 0, 0, 0, 0, 0, 0));
        step("t4_lk34", LK, 32'h0000_3044, 0, ex(ALL, 0, 0, 0, 0, 1, 1, 22'h4));
        step("t4_lk48", LK, 32'h0000_1048, 0, ex(HITD, 1, 0, 32'hA2, 0, 0, 0, 0));

        // 5: invalid beats store
        step("t5_ivst", IV | ST, 32'h0000_1040, 32'h55, ex(HITD, 1, 0, 32'hA0, 0, 0, 0, 0));
        step("t5_lk10", LK, 32'h0000_1040, 0, ex(MISS | C_VAL | C_DRT, 0, 0, 0, 0, 0, 0, 0));
        step("t5_lk24", LK, 32'h0000_2044, 0, ex(HITD | C_VIC, 1, 1, 32'hB1, 0, 0, 0, 0));

        // 6: reset during refill discards the partial line
        step("t6_st0", ST, 32'h0000_5040, 32'hC0, ex(MISS | C_VAL, 0, 0, 0, 0, 0, 0, 0));
        step("t6_st1", ST, 32'h0000_5044, 32'hC1, ex(HITW, 1, 0, 0, 0, 0, 0, 0));
        store = 1'b1;
        addr  = 32'h0000_5048;
        din   = 32'hC2;
        #2 rst = 1'b0;
        #1 check_outputs_zero("t6_async");
        store = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        step("t6_lk50", LK, 32'h0000_5040, 0, ex(MISS | C_VAL | C_DRT, 0, 0, 0, 0, 0, 0, 0));
        step("t6_lk20", LK, 32'h0000_2040, 0, ex(MISS | C_VAL, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
